dmem_lsu: RTL and testbench
===========================

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001: Parameter ADDR_WIDTH, default 8, SHALL be the byte-address width; lane word address width SHALL be ADDR_WIDTH-2.
REQ-002: CLK  in  1  single clock; all state on rising edge.
REQ-003: RST  in  1  reset, asynchronous, active-high.
REQ-004: REQ_VALID  in  1  MEM-stage access request valid.
REQ-005: REQ_READY  out  1  request accepted when REQ_VALID&&REQ_READY.
REQ-006: REQ_WE  in  1  1=store, 0=load.
REQ-007: REQ_FUNCT3  in  3  RV32I width code: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
REQ-008: REQ_ADDR  in  ADDR_WIDTH  byte address; misaligned addresses permitted.
REQ-009: REQ_WDATA  in  32  store data, LSB-aligned.
REQ-010: RSP_VALID  out  1  load response valid.
REQ-011: RSP_READY  in  1  consumer accepts response.
REQ-012: RSP_RDATA  out  32  extended load data.
REQ-013: RSP_ERR  out  1  illegal funct3 on load.
REQ-014: LANE_ADDR  out  4*(ADDR_WIDTH-2)  per-lane word address, lane i at [i*(ADDR_WIDTH-2) +: ADDR_WIDTH-2]; drives both W_ADDR and R_ADDR of byte-lane RAM i.
REQ-015: LANE_WE  out  4  per-lane write enable.
REQ-016: LANE_RE  out  4  per-lane read enable.
REQ-017: LANE_DIN  out  32  lane i write byte at [8i+7:8i].
REQ-018: LANE_DOUT  in  32  lane i registered read byte (1-cycle RAM latency; holds when RE low).

Function
REQ-019: offset=REQ_ADDR[1:0], word=REQ_ADDR[ADDR_WIDTH-1:2], size=1/2/4 bytes for B/H/W.
REQ-020: Lane i SHALL carry access byte k=(i-offset) mod 4 and SHALL be enabled iff k<size.
REQ-021: Lane i address SHALL be word+1 if i<offset else word, modulo 2^(ADDR_WIDTH-2) (wrap at top of memory, no error).
REQ-022: LANE_WE/LANE_RE/LANE_ADDR/LANE_DIN SHALL be combinational from the request, gated by acceptance; write lands at the acceptance edge; no enable asserted otherwise.
REQ-023: Stores SHALL produce no response; REQ_READY stays high in IDLE, allowing one store per cycle.
REQ-024: FSM states IDLE, LOAD_WAIT, RESP; IDLE-(load accepted)->LOAD_WAIT-(always)->RESP-(RSP_READY)->IDLE.
REQ-025: REQ_READY SHALL be 1 only in IDLE with RST low.
REQ-026: In LOAD_WAIT, byte k of result = LANE_DOUT lane (offset+k) mod 4; LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; registered into RSP_RDATA at LOAD_WAIT exit.
REQ-027: Load latency: RSP_VALID high exactly 2 cycles after the acceptance edge.
REQ-028: In RESP, RSP_VALID=1 and RSP_RDATA/RSP_ERR SHALL hold stable until RSP_READY sampled high.
REQ-029: Illegal funct3 (load 011/110/111, store >=011): no lane enables; store silently dropped; load completes the FSM with RSP_ERR=1, RSP_RDATA=0.
REQ-030: offset, funct3 and error flag SHALL be registered at acceptance for use in LOAD_WAIT.

Reset
REQ-031: RST high SHALL immediately force state IDLE, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, REQ_READY=0, all lane enables 0.
REQ-032: A load in flight at reset SHALL be discarded; no response after release.
REQ-033: First request SHALL be acceptable in the first cycle after RST deasserts.

Structure
REQ-034: Shared package dmem_pkg SHALL hold funct3 codes, FSM state encoding and size constants.
REQ-035: Sub-module dmem_load_align (combinational lane rotate + sign/zero extend) SHALL be instantiated once; the four byte-lane RAMs sit outside this block.

Verification (ADDR_WIDTH=8, RAMs zeroed)
REQ-036: SW 0x10 data 0xDEADBEEF -> LANE_WE=1111, lanes 0..3 addr 4 get EF,BE,AD,DE; then LB 0x13 -> RSP_RDATA 0xFFFFFFDE two cycles after accept; LBU 0x13 -> 0x000000DE.
REQ-037: SW 0x11 data 0x11223344 -> lanes1-3 addr 4 = 44,33,22, lane0 addr 5 = 11; LW 0x11 -> 0x11223344; LH 0x13 -> 0x00001122.
REQ-038: SH 0xFF data 0x8877 -> lane3 addr 63 = 77, lane0 addr 0 = 88 (wrap); LH 0xFF -> 0xFFFF8877.
REQ-039: LW with RSP_READY low 3 cycles -> RSP_VALID and RSP_RDATA stable, REQ_READY=0 throughout; released on RSP_READY.
REQ-040: Load funct3 011 -> LANE_RE=0000, RSP_ERR=1, RSP_RDATA=0; store funct3 011 -> LANE_WE=0000, memory unchanged.
REQ-041: RST pulsed during LOAD_WAIT -> RSP_VALID never asserts, REQ_READY=1 first cycle after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory load/store unit: RV32I width codes,
// access sizes and the request FSM encoding.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] SIZE_NONE = 3'd0;
  localparam logic [2:0] SIZE_B    = 3'd1;
  localparam logic [2:0] SIZE_H    = 3'd2;
  localparam logic [2:0] SIZE_W    = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_RESP      = 2'd2
  } state_t;

  // Bytes touched by an access; SIZE_NONE marks an illegal width code.
  function automatic logic [2:0] access_size(input logic we, input logic [2:0] funct3);
    logic [2:0] size;
    size = SIZE_NONE;
    case (funct3)
      F3_B:    size = SIZE_B;
      F3_H:    size = SIZE_H;
      F3_W:    size = SIZE_W;
      F3_BU:   size = we ? SIZE_NONE : SIZE_B;
      F3_HU:   size = we ? SIZE_NONE : SIZE_H;
      default: size = SIZE_NONE;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Rotates the four byte-lane read bytes back into access order and applies
// the sign or zero extension selected by the load width code.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_lane_dout,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  input  logic        i_err,
  output logic [31:0] o_data
);

  logic [31:0] w_rot;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      logic [1:0] w_lane;
      assign w_lane = i_offset + 2'(gi);
      assign w_rot[8*gi +: 8] = i_lane_dout[8*w_lane +: 8];
    end
  endgenerate

  always_comb begin
    o_data = '0;
    if (!i_err) begin
      case (i_funct3)
        F3_B:    o_data = {{24{w_rot[7]}}, w_rot[7:0]};
        F3_BU:   o_data = {24'h0, w_rot[7:0]};
        F3_H:    o_data = {{16{w_rot[15]}}, w_rot[15:0]};
        F3_HU:   o_data = {16'h0, w_rot[15:0]};
        F3_W:    o_data = w_rot;
        default: o_data = '0;
      endcase
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of four byte-lane RAMs: steers misaligned
// accesses across lanes and returns extended load data two cycles later.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_req_valid,
  output logic                        o_req_ready,
  input  logic                        i_req_we,
  input  logic [2:0]                  i_req_funct3,
  input  logic [ADDR_WIDTH-1:0]       i_req_addr,
  input  logic [31:0]                 i_req_wdata,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic [31:0]                 o_rsp_rdata,
  output logic                        o_rsp_err,
  output logic [4*(ADDR_WIDTH-2)-1:0] o_lane_addr,
  output logic [3:0]                  o_lane_we,
  output logic [3:0]                  o_lane_re,
  output logic [31:0]                 o_lane_din,
  input  logic [31:0]                 i_lane_dout
);

  localparam int WW = ADDR_WIDTH - 2;

  state_t      r_state;
  logic [1:0]  r_offset;
  logic [2:0]  r_funct3;
  logic        r_err;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic          w_accept;
  logic [2:0]    w_size;
  logic [1:0]    w_offset;
  logic [WW-1:0] w_word;
  logic [WW-1:0] w_word_next;
  logic [31:0]   w_load_data;

  assign o_req_ready = (r_state == ST_IDLE) && !i_rst;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_size      = access_size(i_req_we, i_req_funct3);
  assign w_offset    = i_req_addr[1:0];
  assign w_word      = i_req_addr[ADDR_WIDTH-1:2];
  assign w_word_next = w_word + 1'b1;

  // Lane gi carries access byte (gi - offset) mod 4; lanes below the offset
  // belong to the next word, which wraps silently at the top of memory.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic [1:0] w_k;
      logic       w_en;
      assign w_k  = LANE - w_offset;
      assign w_en = w_accept && ({1'b0, w_k} < w_size);
      assign o_lane_we[gi] = w_en && i_req_we;
      assign o_lane_re[gi] = w_en && !i_req_we;
      assign o_lane_addr[gi*WW +: WW] = w_accept ? ((LANE < w_offset) ? w_word_next : w_word) : '0;
      assign o_lane_din[8*gi +: 8]    = w_accept ? i_req_wdata[8*w_k +: 8] : 8'h00;
    end
  endgenerate

  dmem_load_align u_align (
    .i_lane_dout (i_lane_dout),
    .i_offset    (r_offset),
    .i_funct3    (r_funct3),
    .i_err       (r_err),
    .o_data      (w_load_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_offset    <= '0;
      r_funct3    <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && !i_req_we) begin
            r_offset <= w_offset;
            r_funct3 <= i_req_funct3;
            r_err    <= (w_size == SIZE_NONE);
            r_state  <= ST_LOAD_WAIT;
          end
        end
        ST_LOAD_WAIT: begin
          r_rsp_rdata <= w_load_data;
          r_rsp_err   <= r_err;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: directed and random accesses against a flat
// byte-addressed memory model, with four byte-lane RAMs modelled locally.
module tb_dmem_lsu;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [23:0] lane_addr;
  logic [3:0]  lane_we;
  logic [3:0]  lane_re;
  logic [31:0] lane_din;
  logic [31:0] lane_dout;

  logic [7:0] ram [4][64];
  logic       ram_clr;
  logic [7:0] mem [256];
  exp_t       sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hold_cnt = 0;
  bit rand_mode = 0;

  dmem_lsu #(.ADDR_WIDTH(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_funct3 (req_funct3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_err    (rsp_err),
    .o_lane_addr  (lane_addr),
    .o_lane_we    (lane_we),
    .o_lane_re    (lane_re),
    .o_lane_din   (lane_din),
    .i_lane_dout  (lane_dout)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Four byte-lane RAMs with one-cycle registered read that holds when idle.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 64; j++) ram[i][j] <= 8'h00;
      lane_dout <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (lane_we[i]) ram[i][lane_addr[i*6 +: 6]] <= lane_din[i*8 +: 8];
        if (lane_re[i]) lane_dout[i*8 +: 8] <= ram[i][lane_addr[i*6 +: 6]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int ref_size(input logic we, input logic [2:0] f3);
    case (f3)
      3'b000:  return 1;
      3'b001:  return 2;
      3'b010:  return 4;
      3'b100:  return we ? 0 : 1;
      3'b101:  return we ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [7:0] addr);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = mem[(int'(addr) + k) % 256];
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b101:  return {16'h0, w[15:0]};
      3'b010:  return w;
      default: return 32'h0;
    endcase
  endfunction

  // Drive one request, check the lane steering from flat byte addresses,
  // then update the model (store) or push the expected response (load).
  task automatic issue(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                       input logic [31:0] wd, input logic has_exp, input logic [31:0] exp_data);
    int tries;
    int sz;
    logic [3:0]  e_we, e_re;
    logic [23:0] e_addr, m_addr;
    logic [31:0] e_din, m_din;
    exp_t e;
    tries = 0;
    @(negedge clk);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    #1;
    while (!req_ready) begin
      tries++;
      if (tries > 100) begin
        checks++; errors++;
        $display("FAIL accept_timeout: got ready 0 expected 1 within 100 cycles");
        req_valid = 0;
        return;
      end
      @(negedge clk);
      #1;
    end
    sz = ref_size(we, f3);
    e_we = '0; e_re = '0; e_addr = '0; m_addr = '0; e_din = '0; m_din = '0;
    for (int k = 0; k < sz; k++) begin
      int b;
      int ln;
      b  = (int'(addr) + k) % 256;
      ln = b % 4;
      if (we) e_we[ln] = 1'b1; else e_re[ln] = 1'b1;
      e_addr[ln*6 +: 6] = 6'(b / 4);
      m_addr[ln*6 +: 6] = 6'h3f;
      e_din[ln*8 +: 8]  = wd[k*8 +: 8];
      m_din[ln*8 +: 8]  = 8'hff;
    end
    check("lane_we", 32'(lane_we), 32'(e_we));
    check("lane_re", 32'(lane_re), 32'(e_re));
    check("lane_addr", 32'(lane_addr & m_addr), 32'(e_addr));
    if (we) begin
      check("lane_din", lane_din & m_din, e_din);
      for (int k = 0; k < sz; k++) mem[(int'(addr) + k) % 256] = wd[k*8 +: 8];
    end else begin
      e.err  = (sz == 0);
      e.data = has_exp ? exp_data : (e.err ? 32'h0 : ref_load(f3, addr));
      e.cyc  = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!(sb.size() == 0 && req_ready && !rsp_valid) && n < 200);
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got pending %0d expected 0 within 200 cycles", sb.size());
    end
  endtask

  // Response monitor: pops the scoreboard on each new response, checks
  // latency and data, and checks that a stalled response holds steady.
  initial begin
    exp_t        e;
    bit          prev_valid;
    logic [31:0] held_data;
    logic        held_err;
    prev_valid = 0;
    held_data  = '0;
    held_err   = 1'b0;
    rsp_ready  = 1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 0;
        continue;
      end
      if (rsp_valid) begin
        check("req_ready_in_resp", 32'(req_ready), 32'h0);
        if (!prev_valid) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: got data %h err %0d expected no response", rsp_rdata, rsp_err);
          end else begin
            e = sb.pop_front();
            check("rsp_latency", 32'(cyc), 32'(e.cyc + 2));
            check("rsp_rdata", rsp_rdata, e.data);
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            $display("RSP cyc %0d data %h err %0d", cyc, rsp_rdata, rsp_err);
          end
          held_data = rsp_rdata;
          held_err  = rsp_err;
        end else begin
          check("rsp_hold_data", rsp_rdata, held_data);
          check("rsp_hold_err", 32'(rsp_err), 32'(held_err));
        end
        if (hold_cnt > 0) begin
          rsp_ready = 0;
          hold_cnt--;
        end else if (rand_mode) begin
          rsp_ready = ($urandom_range(0, 3) != 0);
        end else begin
          rsp_ready = 1;
        end
        prev_valid = !rsp_ready;
      end else begin
        if (prev_valid) begin
          checks++; errors++;
          $display("FAIL rsp_dropped: got valid 0 expected 1 before handshake");
        end
        prev_valid = 0;
        rsp_ready  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst = 1; ram_clr = 1;
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 8'h10; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_lane_re", 32'(lane_re), 32'h0);
    ram_clr = 0; req_valid = 0; rst = 0;
    #1;
    check("ready_after_rst", 32'(req_ready), 32'h1);

    issue(1, 3'b010, 8'h10, 32'hDEADBEEF, 0, 0);
    check("ram_l0_w4", 32'(ram[0][4]), 32'hEF);
    check("ram_l1_w4", 32'(ram[1][4]), 32'hBE);
    check("ram_l2_w4", 32'(ram[2][4]), 32'hAD);
    check("ram_l3_w4", 32'(ram[3][4]), 32'hDE);
    issue(0, 3'b000, 8'h13, 0, 1, 32'hFFFFFFDE); wait_idle();
    issue(0, 3'b100, 8'h13, 0, 1, 32'h000000DE); wait_idle();

    issue(1, 3'b010, 8'h11, 32'h11223344, 0, 0);
    check("ram_l1_w4b", 32'(ram[1][4]), 32'h44);
    check("ram_l2_w4b", 32'(ram[2][4]), 32'h33);
    check("ram_l3_w4b", 32'(ram[3][4]), 32'h22);
    check("ram_l0_w5", 32'(ram[0][5]), 32'h11);
    issue(0, 3'b010, 8'h11, 0, 1, 32'h11223344); wait_idle();
    issue(0, 3'b001, 8'h13, 0, 1, 32'h00001122); wait_idle();

    issue(1, 3'b001, 8'hFF, 32'h00008877, 0, 0);
    check("ram_l3_w63", 32'(ram[3][63]), 32'h77);
    check("ram_l0_w0", 32'(ram[0][0]), 32'h88);
    issue(0, 3'b001, 8'hFF, 0, 1, 32'hFFFF8877); wait_idle();

    // Reset pulse while the load is in LOAD_WAIT: the load must vanish.
    issue(0, 3'b010, 8'h10, 0, 0, 0);
    rst = 1;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midrst_req_ready", 32'(req_ready), 32'h0);
    check("midrst_rsp_rdata", rsp_rdata, 32'h0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check("ready_after_midrst", 32'(req_ready), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("no_rsp_after_rst", 32'(rsp_valid), 32'h0);
    end

    hold_cnt = 3;
    issue(0, 3'b010, 8'h10, 0, 1, 32'h223344EF); wait_idle();

    issue(0, 3'b011, 8'h10, 0, 1, 32'h0); wait_idle();
    issue(0, 3'b110, 8'h31, 0, 1, 32'h0); wait_idle();
    issue(1, 3'b011, 8'h20, 32'hFFFFFFFF, 0, 0);
    issue(1, 3'b100, 8'h24, 32'hFFFFFFFF, 0, 0);
    issue(0, 3'b010, 8'h20, 0, 1, 32'h0); wait_idle();
    issue(0, 3'b010, 8'h24, 0, 1, 32'h0); wait_idle();

    rand_mode = 1;
    for (int n = 0; n < 300; n++) begin
      logic       we;
      logic [2:0] f3;
      logic [7:0] addr;
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 8'($urandom_range(0, 40) + 240);
      issue(we, f3, addr, $urandom, 0, 0);
    end
    wait_idle();
    rand_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
